// File: rtl/instr_encode_loader.sv
// Instruction encoder / program loader.
// Packs structured instruction requests (R, I, LW, SW, BEQ-class) into RV32I words.
// Each legal request is written to the next consecutive instruction-memory word address.
// Illegal requests are consumed without a write and raise a sticky error flag.

module instr_encode_loader #(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_kind,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [12:0]       in_imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FULL = 2'd2
   } state_t;

   // Memory capacity in words, and the count at which one free word remains.
   localparam logic [ADDR_W:0]   CAP       = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   LAST      = {1'b0, {ADDR_W{1'b1}}};
   localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t              state_q;
   logic [ADDR_W-1:0]   wptr_q;
   logic [ADDR_W:0]     count_q;
   logic                memWe_q;
   logic [ADDR_W-1:0]   memAddr_q;
   logic [31:0]         memWdata_q;
   logic                err_q;

   logic [31:0]         memWdata_d;
   logic                illegal_d;
   logic                accept;

   // start always takes priority over a request arriving in the same cycle.
   assign in_ready = (state_q == LOAD) && !start;
   assign accept   = in_valid && in_ready;

   // Pack the request fields into the RV32I word for its kind; flag kinds we cannot encode.
   always_comb begin
      memWdata_d = 32'h0000_0000;
      illegal_d  = 1'b0;
      case (in_kind)
         3'd0: memWdata_d = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
         3'd1: memWdata_d = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
         3'd2: memWdata_d = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
         3'd3: memWdata_d = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
         3'd4: begin
            memWdata_d = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], 7'b1100011};
            illegal_d  = in_imm[0];
         end
         default: illegal_d = 1'b1;
      endcase
   end

   // Load FSM: tracks the write pointer and word count and registers the memory write port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         wptr_q     <= '0;
         count_q    <= '0;
         memWe_q    <= 1'b0;
         memAddr_q  <= '0;
         memWdata_q <= 32'h0000_0000;
         err_q      <= 1'b0;
      end else begin
         memWe_q <= 1'b0;
         if (start) begin
            state_q <= LOAD;
            wptr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
         end else if (accept) begin
            if (illegal_d) begin
               err_q <= 1'b1;
            end else begin
               memWe_q    <= 1'b1;
               memAddr_q  <= wptr_q;
               memWdata_q <= memWdata_d;
               wptr_q     <= wptr_q + PTR_ONE;
               count_q    <= count_q + COUNT_ONE;
               if (count_q == LAST) begin
                  state_q <= FULL;
               end
            end
         end
      end
   end

   assign mem_we    = memWe_q;
   assign mem_addr  = memAddr_q;
   assign mem_wdata = memWdata_q;
   assign count     = count_q;
   assign full      = (count_q == CAP);
   assign err       = err_q;

endmodule
